dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder serving the core's load/store port: accepts a read or write request from the core (the initiator), performs it on an internal word array after a configurable number of wait states, and returns a one-cycle `ready` acknowledgement with read data. It sits between the core's data-side outputs (`MemRead`, `MemWrite`, ALU-computed address, `ddata_w`) and `ddata_r`. It replaces the zero-latency data RAM when multi-cycle memory timing must be exercised.

## Interface
- `data_size`, 1024, number of 32-bit words in the array.
- `address_size`, 32, width of the byte address and data buses.
- `WAIT_STATES`, 1, extra cycles between request capture and array access (0..15).

Ports:
- `CLK` in 1: sole clock, rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `MemRead` in 1: read request, sampled when the block is not busy.
- `MemWrite` in 1: write request, sampled when the block is not busy.
- `addr` in `address_size`: byte address. Word index is `addr[$clog2(data_size)+1:2]`.
- `ddata_w` in `address_size`: write data.
- `be` in 4: byte enables for writes. `be[i]` covers `ddata_w[8i+7:8i]`.
- `ddata_r` out `address_size`: read data, valid while `ready`=1 and held until the next response.
- `ready` out 1: response strobe, high for exactly one cycle per accepted request.
- `busy` out 1: high when the state is not IDLE.
- `err` out 1: error flag, qualified by `ready` (see Configuration).

## Operation
- States: IDLE, WAIT, ACCESS, RESP. All outputs are registered.
- **IDLE or RESP with `MemRead|MemWrite`=1 at an edge:**
  - Capture `addr`, `ddata_w`, `be`, and the operation.
  - Load the wait counter with `WAIT_STATES`.
  - Go to WAIT, or go directly to ACCESS if `WAIT_STATES`=0.
- **RESP with no request:** go to IDLE.
- **WAIT:** decrement the counter at each edge. At the edge where the counter is 1, go to ACCESS.
- **ACCESS:** at the exiting edge:
  - Write: update each byte lane whose captured `be` bit is 1.
  - Read: load `ddata_r` with the array word.
  - Set `ready`<=1 and go to RESP.
- **RESP:** `ready`=1 for this cycle only.
- Both `MemRead` and `MemWrite` high: treated as a write; `ddata_r` keeps its previous value.
- Requests arriving in WAIT or ACCESS are ignored. They are not queued.
- Out of range (word index ≥ `data_size`, or upper address bits nonzero): the write is dropped, a read returns 0, and `ready` is still produced.
- `be`=0000 on a write: no byte is changed, and `ready` is still produced.
- Read-after-write to the same word in back-to-back requests returns the new data.

## Timing
- Request held high at edge E: `ready`=1 in the cycle after edge E+1+`WAIT_STATES`.
  - Latency is `WAIT_STATES`+2 edges.
  - With the default `WAIT_STATES`=1, `ready` is seen 3 edges after the request.
- `busy`=1 from after edge E until the return to IDLE.
- `busy` stays 1 across back-to-back requests accepted from RESP.
- Peak throughput: one request per `WAIT_STATES`+2 cycles.
- Reset values: state IDLE, `ready`=0, `busy`=0, `err`=0, `ddata_r`=0, wait counter 0.
- Array contents are not cleared by reset.
- Reset asserted in WAIT or ACCESS: the pending operation is aborted.
  - A write that has not yet reached the ACCESS exit edge is not performed.
  - No `ready` is issued.
- Reset and a request at the same edge: reset wins and the request is lost.

## Configuration
- Macro: `DMEM_MISALIGN_CHECK_EN`.
- **Defined:** a captured request is flagged when either condition holds:
  - `addr[1:0]`≠0 with `be`=1111;
  - `addr[1]`=1 with `be`=0011 or `be`=1100.
  
  A flagged request performs no array update, returns `ddata_r`=0, and asserts `err`=1 together with `ready`.
- **Undefined:** `addr[1:0]` is ignored, all accesses are word-aligned, and `err` is tied to 0.

## Test plan
- Reset, then `MemWrite`, `addr`=0x10, `ddata_w`=0xDEADBEEF, `be`=1111, then read 0x10 → `ready` exactly 3 edges after each request and `ddata_r`=0xDEADBEEF. `busy` is 0 after reset.
- Write 0x11223344 to 0x20, then write `be`=0010 with `ddata_w`=0x0000AA00, then read → `ddata_r`=0x1122AA44.
- Back-to-back requests presented during RESP → the second is accepted with no IDLE cycle, `busy` stays 1, and two `ready` pulses arrive 3 cycles apart. A request asserted during WAIT produces no extra `ready`.
- Read `addr`=0x1000 (word 1024) → `ddata_r`=0 with `ready`=1. Write to 0x1000 leaves word 0 unchanged.
- Write 0x55 to 0x30 and assert `RESET` during WAIT → no `ready`, and a subsequent read of 0x30 returns the old contents. `WAIT_STATES`=0 build: `ready` 2 edges after the request.
- With `DMEM_MISALIGN_CHECK_EN`: word write to 0x42 → `err`=1 with `ready`, and a read of 0x40 is unchanged. Without the macro: `err`=0 and word 0x40 is written.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the core's load/store port.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned requests on err; otherwise err is tied to 0.
module dmem_responder #(
  parameter int data_size    = 1024,
  parameter int address_size = 32,
  parameter int WAIT_STATES  = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [address_size-1:0] addr,
  input  logic [address_size-1:0] ddata_w,
  input  logic [3:0]              be,
  output logic [address_size-1:0] ddata_r,
  output logic                    ready,
  output logic                    busy,
  output logic                    err
);

  localparam int         IDX_W     = $clog2(data_size);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    wr_q;
  logic                    range_q;
  logic                    flag_q;
  logic [IDX_W-1:0]        idx_q;
  logic [address_size-1:0] data_q;
  logic [3:0]              be_q;
  logic [address_size-1:0] mem [data_size];

  logic                    req;
  logic                    req_in_range;
  logic                    req_flag;
  logic                    mem_we;
  logic [IDX_W-1:0]        req_idx;

  assign req          = MemRead | MemWrite;
  assign req_idx      = addr[IDX_W+1:2];
  // Any address bit above the word index makes the request out of range.
  assign req_in_range = (int'(req_idx) < data_size) && ((addr >> (IDX_W + 2)) == '0);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign req_flag = ((addr[1:0] != 2'b00) && (be == 4'b1111)) ||
                    (addr[1] && ((be == 4'b0011) || (be == 4'b1100)));
`else
  assign req_flag = 1'b0;
`endif

  assign mem_we = (state_q == S_ACCESS) && !RESET && wr_q && range_q && !flag_q;

  // NOTE: the array is kept out of reset so it maps onto plain RAM; its contents survive RESET.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      ddata_r <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state_q)
        S_IDLE, S_RESP: begin
          if (req) begin
            // A simultaneous read and write is treated as a write.
            wr_q    <= MemWrite;
            idx_q   <= req_idx;
            range_q <= req_in_range;
            flag_q  <= req_flag;
            data_q  <= ddata_w;
            be_q    <= be;
            cnt_q   <= WAIT_INIT;
            state_q <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            busy    <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          if (flag_q) begin
            ddata_r <= '0;
          end else if (!wr_q) begin
            ddata_r <= range_q ? mem[idx_q] : '0;
          end
          ready   <= 1'b1;
          err     <= flag_q;
          state_q <= S_RESP;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_dmem_responder;

  localparam int WS = 1;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MemRead, MemWrite;
  logic [31:0] addr, ddata_w;
  logic [3:0]  be;
  logic [31:0] ddata_r;
  logic        ready, busy, err;

  logic        MemRead0, MemWrite0;
  logic [31:0] addr0, ddata_w0;
  logic [3:0]  be0;
  logic [31:0] ddata_r0;
  logic        ready0, busy0, err0;

  always #5 CLK = ~CLK;

  dmem_responder #(.data_size(1024), .address_size(32), .WAIT_STATES(WS)) u_dut (
    .CLK(CLK), .RESET(RESET), .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr),
    .ddata_w(ddata_w), .be(be), .ddata_r(ddata_r), .ready(ready), .busy(busy), .err(err)
  );

  dmem_responder #(.data_size(1024), .address_size(32), .WAIT_STATES(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .MemRead(MemRead0), .MemWrite(MemWrite0), .addr(addr0),
    .ddata_w(ddata_w0), .be(be0), .ddata_r(ddata_r0), .ready(ready0), .busy(busy0), .err(err0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction described by its acceptance edge and
  // the edge at which its response appears (acceptance + 1 + WS).
  int unsigned edge_n = 0;
  bit          t_valid = 1'b0;
  int unsigned t_resp;
  bit          t_wr, t_oor, t_flag;
  int          t_idx;
  logic [31:0] t_data;
  logic [3:0]  t_be;
  logic [31:0] m_mem [1024];
  logic [31:0] e_rdata;
  bit          e_ready, e_busy, e_err;
  bit          chk_en = 1'b0;

  function automatic bit misaligned(input logic [31:0] a, input logic [3:0] b);
`ifdef DMEM_MISALIGN_CHECK_EN
    return ((a % 4) != 0 && b == 4'hF) || (a[1] && (b == 4'h3 || b == 4'hC));
`else
    return (a === 32'hx) && (b === 4'hx);
`endif
  endfunction

  always @(posedge CLK) begin
    edge_n++;
    if (RESET) begin
      t_valid = 1'b0;
      e_ready = 1'b0;
      e_busy  = 1'b0;
      e_err   = 1'b0;
      e_rdata = '0;
    end else begin
      e_ready = 1'b0;
      e_err   = 1'b0;
      if (t_valid && edge_n == t_resp) begin
        e_ready = 1'b1;
        if (t_flag) begin
          e_err   = 1'b1;
          e_rdata = '0;
        end else if (t_wr) begin
          if (!t_oor)
            for (int i = 0; i < 4; i++)
              if (t_be[i]) m_mem[t_idx][8*i +: 8] = t_data[8*i +: 8];
        end else begin
          e_rdata = t_oor ? 32'd0 : m_mem[t_idx];
        end
      end
      if ((MemRead || MemWrite) && (!t_valid || edge_n > t_resp)) begin
        t_valid = 1'b1;
        t_resp  = edge_n + 1 + WS;
        t_wr    = MemWrite;
        t_oor   = (addr >= 32'h1000);
        t_idx   = int'(addr / 4) % 1024;
        t_flag  = misaligned(addr, be);
        t_data  = ddata_w;
        t_be    = be;
      end
      e_busy = t_valid && (edge_n <= t_resp);
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("ready", 32'(ready), 32'(e_ready));
      check("busy", 32'(busy), 32'(e_busy));
      check("err", 32'(err), 32'(e_err));
      check("ddata_r", ddata_r, e_rdata);
    end
  end

  // Called at a negedge; returns at the negedge right after the request edge.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    ddata_w  = d;
    be       = b;
    @(negedge CLK);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  // Edge count includes the request edge itself.
  task automatic wait_ready(input string name, output int edges, output logic [31:0] data);
    edges = 1;
    data  = 'x;
    while (edges < 20) begin
      @(negedge CLK);
      edges++;
      if (ready) begin
        data = ddata_r;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no ready within %0d edges", name, edges);
  endtask

  task automatic rd_word(input string name, input logic [31:0] a, input logic [31:0] exp);
    int          e;
    logic [31:0] d;
    issue(1'b1, 1'b0, a, 32'h0, 4'h0);
    wait_ready(name, e, d);
    check({name, " data"}, d, exp);
  endtask

  task automatic wr_word(input string name, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    int          e;
    logic [31:0] r;
    issue(1'b0, 1'b1, a, d, b);
    wait_ready(name, e, r);
  endtask

  initial begin
    int          e;
    int          pulses;
    logic [31:0] d;
    logic        err_seen;

    RESET = 1'b1;
    {MemRead, MemWrite, addr, ddata_w, be} = '0;
    {MemRead0, MemWrite0, addr0, ddata_w0, be0} = '0;
    @(negedge CLK);
    chk_en = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset ready", 32'(ready), 32'd0);
    check("reset ddata_r", ddata_r, 32'd0);
    check("reset busy ws0", 32'(busy0), 32'd0);

    for (int i = 0; i < 32; i++) wr_word("init", 32'(i * 4), 32'hC0DE0000 + 32'(i), 4'hF);

    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_ready("wr 0x10", e, d);
    check("wr latency", 32'(e), 32'd3);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_ready("rd 0x10", e, d);
    check("rd latency", 32'(e), 32'd3);
    check("rd 0x10 data", d, 32'hDEADBEEF);

    wr_word("wr 0x20", 32'h20, 32'h11223344, 4'hF);
    wr_word("wr 0x20 lane1", 32'h20, 32'h0000AA00, 4'b0010);
    rd_word("rd 0x20", 32'h20, 32'h1122AA44);

    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_ready("b2b first", e, d);
    check("b2b busy in resp", 32'(busy), 32'd1);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    check("b2b busy after accept", 32'(busy), 32'd1);
    wait_ready("b2b second", e, d);
    check("b2b pulse spacing", 32'(e), 32'd3);
    check("b2b second data", d, 32'h1122AA44);
    @(negedge CLK);

    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    MemWrite = 1'b1;
    addr     = 32'h10;
    ddata_w  = 32'hBAD0BAD0;
    be       = 4'hF;
    @(negedge CLK);
    MemWrite = 1'b0;
    pulses = 0;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (ready) begin
        pulses++;
        d = ddata_r;
      end
    end
    check("wait-state request ignored", 32'(pulses), 32'd1);
    check("wait-state read data", d, 32'hDEADBEEF);
    rd_word("no queued write", 32'h10, 32'hDEADBEEF);

    rd_word("rd oor", 32'h1000, 32'h0);
    wr_word("wr oor", 32'h1000, 32'hFFFFFFFF, 4'hF);
    rd_word("word0 untouched", 32'h0, 32'hC0DE0000);

    issue(1'b0, 1'b1, 32'h30, 32'h55, 4'hF);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (ready) pulses++;
    end
    check("abort no ready", 32'(pulses), 32'd0);
    rd_word("abort old data", 32'h30, 32'hC0DE000C);

    issue(1'b0, 1'b1, 32'h42, 32'hCAFEF00D, 4'hF);
    wait_ready("misalign wr", e, d);
    err_seen = err;
`ifdef DMEM_MISALIGN_CHECK_EN
    check("misalign err", 32'(err_seen), 32'd1);
    rd_word("misalign word", 32'h40, 32'hC0DE0010);
`else
    check("misalign err", 32'(err_seen), 32'd0);
    rd_word("misalign word", 32'h40, 32'hCAFEF00D);
`endif

    MemWrite0 = 1'b1;
    addr0     = 32'h8;
    ddata_w0  = 32'h12345678;
    be0       = 4'hF;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      MemRead0  = (k == 0);
      MemWrite0 = 1'b0;
      e = 1;
      while (!ready0 && e < 20) begin
        @(negedge CLK);
        e++;
        if (k == 0 && e == 2) MemRead0 = 1'b0;
      end
      check("ws0 latency", 32'(e), 32'd2);
      if (k == 1) check("ws0 rd data", ddata_r0, 32'h12345678);
      MemRead0 = (k == 0);
    end
    MemRead0 = 1'b0;
    repeat (3) @(negedge CLK);

    for (int k = 0; k < 400; k++) begin
      MemRead  = 1'($urandom_range(0, 1));
      MemWrite = 1'($urandom_range(0, 1));
      addr     = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 127));
      ddata_w  = $urandom;
      be       = 4'($urandom);
      RESET    = ($urandom_range(0, 49) == 0);
      repeat ($urandom_range(1, 5)) @(negedge CLK);
      RESET    = 1'b0;
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    repeat (6) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
